// File: rtl/foc_pkg.sv
// Shared FOC definitions: constant ROM geometry and named ROM addresses.
// No ports; imported by the constant-ROM arbiter and its users.
package foc_pkg;

  localparam int FOC_CONST_AW = 5;
  localparam int FOC_DW       = 32;

  // Named entries of the 32x32 single-precision constant ROM.
  localparam logic [FOC_CONST_AW-1:0] CONST_NEG_16384 = 5'h00;
  localparam logic [FOC_CONST_AW-1:0] CONST_ADC_SCALE = 5'h01;
  localparam logic [FOC_CONST_AW-1:0] CONST_PWM_ZERO  = 5'h09;
  localparam logic [FOC_CONST_AW-1:0] CONST_PWM_MAX   = 5'h0B;
  localparam logic [FOC_CONST_AW-1:0] CONST_TWO_PI    = 5'h0F;
  localparam logic [FOC_CONST_AW-1:0] CONST_ZERO      = 5'h1F;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Scans req_i starting at index ptr_i, wrapping modulo N, and returns the
// first requester found.
//   req_i  : N-bit request vector
//   ptr_i  : highest-priority index this cycle
//   gnt_o  : one-hot grant (zero when no request)
//   idx_o  : encoded index of the grant (zero when no request)
//   any_o  : at least one request present
module rr_pick #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    logic found;
    int   j;
    found = 1'b0;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    for (int k = 0; k < N; k++) begin
      // Rotate from ptr_i; one subtraction suffices since ptr_i < N.
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/foc_const_arb.sv
// Round-robin arbiter sharing the single-port FOC constant ROM.
//   c        : clock
//   r        : synchronous active-high reset
//   req      : per-requester read request, held until ack
//   req_addr : packed addresses, requester i at [i*AW +: AW]
//   ack      : one-hot combinational grant, consumed at next edge
//   rom_addr : registered ROM address
//   rom_q    : ROM registered output
//   rdata    : returned constant (straight from rom_q)
//   rvalid   : one-hot tag, rdata belongs to requester i when rvalid[i]
// Two-stage pipe: grant edge loads rom_addr and tag0; next edge the ROM
// reads and tag0 moves to rvalid, so tag and data line up.
module foc_const_arb
  import foc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int AW      = FOC_CONST_AW,
  parameter int DW      = FOC_DW
) (
  input  logic                  c,
  input  logic                  r,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  output logic [NUM_REQ-1:0]    ack,
  output logic [AW-1:0]         rom_addr,
  input  logic [DW-1:0]         rom_q,
  output logic [DW-1:0]         rdata,
  output logic [NUM_REQ-1:0]    rvalid
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]      rom_addr_q, rom_addr_d;
  logic [NUM_REQ-1:0] tag0_q, tag0_d;
  logic [NUM_REQ-1:0] rvalid_q;

  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      win_idx;
  logic               win_any;
  logic [AW-1:0]      win_addr;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // Reset suppresses the grant so no requester drops a request that the
  // pipeline is about to discard.
  assign ack = r ? '0 : gnt;

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (PW'(i) == win_idx) win_addr = req_addr[i*AW +: AW];
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rom_addr_d = rom_addr_q;
    tag0_d     = '0;
    if (win_any) begin
      rom_addr_d = win_addr;
      tag0_d     = gnt;
      rr_ptr_d   = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
    end
  end

  always_ff @(posedge c) begin
    if (r) begin
      rr_ptr_q   <= '0;
      rom_addr_q <= '0;
      tag0_q     <= '0;
      rvalid_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rom_addr_q <= rom_addr_d;
      tag0_q     <= tag0_d;
      rvalid_q   <= tag0_q;
    end
  end

  assign rom_addr = rom_addr_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rom_q;

endmodule

// File: tb/tb_foc_const_arb.sv
module tb_foc_const_arb;
  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          c = 1'b0;
  logic          r = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]  ack;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q;
  logic [DW-1:0] rdata;
  logic [N-1:0]  rvalid;

  int checks = 0;
  int failures = 0;

  foc_const_arb #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
    .c(c), .r(r), .req(req), .req_addr(req_addr), .ack(ack),
    .rom_addr(rom_addr), .rom_q(rom_q), .rdata(rdata), .rvalid(rvalid)
  );

  always #5 c = ~c;

  // Constant ROM model: registered output, one-cycle read.
  function automatic logic [31:0] rom_word(input logic [4:0] a);
    case (a)
      5'h00: return 32'hc680_0000;
      5'h01: return 32'h3bd5_5555;
      5'h02: return 32'h3f2a_aaab;
      5'h09: return 32'h451f_f000;
      5'h0a: return 32'h424c_b852;
      5'h0b: return 32'h459f_f800;
      5'h0d: return 32'h3f00_0000;
      5'h0f: return 32'h40c9_0fdb;
      default: return (a >= 5'h12) ? 32'h0 : 32'h3f80_0000;
    endcase
  endfunction

  always @(posedge c) rom_q <= rom_word(rom_addr);

  task automatic tick;
    @(posedge c); #1;
  endtask

  task automatic do_reset;
    r = 1'b1; req = '0; req_addr = '0;
    tick();
    r = 1'b0;
  endtask

  task automatic test_reset;
    r = 1'b1; req = 4'b1111;
    req_addr = {5'h0f, 5'h0b, 5'h09, 5'h01};
    tick(); tick();
    #1;
    checks++;
    if (ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    tick();
    checks++;
    if (rom_addr !== 5'h00) begin failures++; $display("FAIL reset_rom_addr got=%h exp=00", rom_addr); end
    checks++;
    if (rvalid !== 4'b0000) begin failures++; $display("FAIL reset_rvalid got=%b exp=0000", rvalid); end
    r = 1'b0; req = '0;
    tick();
  endtask

  task automatic test_single;
    do_reset();
    req = 4'b0001; req_addr[0*AW +: AW] = 5'h01;
    #1;
    checks++;
    if (ack !== 4'b0001) begin failures++; $display("FAIL single_ack got=%b exp=0001", ack); end
    tick();
    req = 4'b0000;
    checks++;
    if (rom_addr !== 5'h01) begin failures++; $display("FAIL single_rom_addr got=%h exp=01", rom_addr); end
    checks++;
    if (rvalid !== 4'b0000) begin failures++; $display("FAIL single_early_rvalid got=%b exp=0000", rvalid); end
    tick();
    checks++;
    if (rvalid !== 4'b0001) begin failures++; $display("FAIL single_rvalid got=%b exp=0001", rvalid); end
    checks++;
    if (rdata !== 32'h3bd5_5555) begin failures++; $display("FAIL single_rdata got=%h exp=3bd55555", rdata); end
    tick();
    checks++;
    if (rvalid !== 4'b0000) begin failures++; $display("FAIL single_rvalid_pulse got=%b exp=0000", rvalid); end
  endtask

  task automatic test_all_four;
    logic [31:0] exp_d [4];
    logic [N-1:0] e;
    exp_d = '{32'hc680_0000, 32'h459f_f800, 32'h40c9_0fdb, 32'h0000_0000};
    do_reset();
    req = 4'b1111;
    req_addr = {5'h1f, 5'h0f, 5'h0b, 5'h00};
    for (int k = 0; k < 6; k++) begin
      #1;
      e = (k < 4) ? (4'b0001 << k) : 4'b0000;
      checks++;
      if (ack !== e) begin failures++; $display("FAIL rotate_ack cyc=%0d got=%b exp=%b", k, ack, e); end
      if (k >= 2) begin
        e = 4'b0001 << (k - 2);
        checks++;
        if (rvalid !== e) begin failures++; $display("FAIL rotate_rvalid cyc=%0d got=%b exp=%b", k, rvalid, e); end
        checks++;
        if (rdata !== exp_d[k-2]) begin failures++; $display("FAIL rotate_rdata cyc=%0d got=%h exp=%h", k, rdata, exp_d[k-2]); end
      end
      tick();
      if (k < 4) req[k] = 1'b0;
    end
  endtask

  task automatic test_stream;
    logic [4:0]  addrs [3];
    logic [31:0] exp_d [3];
    addrs = '{5'h09, 5'h0a, 5'h0d};
    exp_d = '{32'h451f_f000, 32'h424c_b852, 32'h3f00_0000};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin req = 4'b0100; req_addr[2*AW +: AW] = addrs[k]; end
      else req = 4'b0000;
      #1;
      checks++;
      if (ack !== ((k < 3) ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL stream_ack cyc=%0d got=%b", k, ack); end
      if (k >= 2) begin
        checks++;
        if (rvalid !== 4'b0100) begin failures++; $display("FAIL stream_rvalid cyc=%0d got=%b exp=0100", k, rvalid); end
        checks++;
        if (rdata !== exp_d[k-2]) begin failures++; $display("FAIL stream_rdata cyc=%0d got=%h exp=%h", k, rdata, exp_d[k-2]); end
      end
      tick();
    end
  endtask

  task automatic test_fairness;
    logic [N-1:0] e;
    do_reset();
    req_addr[0*AW +: AW] = 5'h00;
    req_addr[3*AW +: AW] = 5'h0f;
    for (int k = 0; k < 5; k++) begin
      req = (k >= 2) ? 4'b1001 : 4'b0001;
      #1;
      // k=2: ptr=1 so requester 3 wins; k=3: ptr wrapped to 0.
      e = (k == 2 || k == 4) ? 4'b1000 : 4'b0001;
      checks++;
      if (ack !== e) begin failures++; $display("FAIL fair_ack cyc=%0d got=%b exp=%b", k, ack, e); end
      if (k == 4) begin
        checks++;
        if (rvalid !== 4'b1000) begin failures++; $display("FAIL fair_rvalid got=%b exp=1000", rvalid); end
        checks++;
        if (rdata !== 32'h40c9_0fdb) begin failures++; $display("FAIL fair_rdata got=%h exp=40c90fdb", rdata); end
      end
      tick();
    end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_reset_inflight;
    do_reset();
    req = 4'b0001; req_addr[0*AW +: AW] = 5'h02;
    #1;
    checks++;
    if (ack !== 4'b0001) begin failures++; $display("FAIL rstfly_grant got=%b exp=0001", ack); end
    tick();
    r = 1'b1; req = 4'b0001;
    #1;
    checks++;
    if (ack !== 4'b0000) begin failures++; $display("FAIL rstfly_ack got=%b exp=0000", ack); end
    tick();
    r = 1'b0; req = 4'b0000;
    checks++;
    if (rvalid !== 4'b0000) begin failures++; $display("FAIL rstfly_rvalid got=%b exp=0000", rvalid); end
    checks++;
    if (rom_addr !== 5'h00) begin failures++; $display("FAIL rstfly_rom_addr got=%h exp=00", rom_addr); end
    tick();
    checks++;
    if (rvalid !== 4'b0000) begin failures++; $display("FAIL rstfly_rvalid2 got=%b exp=0000", rvalid); end
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    checks++;
    if (rvalid !== 4'b0001) begin failures++; $display("FAIL rstfly_reissue_rvalid got=%b exp=0001", rvalid); end
    checks++;
    if (rdata !== 32'h3f2a_aaab) begin failures++; $display("FAIL rstfly_reissue_rdata got=%h exp=3f2aaaab", rdata); end
    tick();
  endtask

  task automatic test_withdrawn;
    do_reset();
    req = 4'b0011;
    req_addr[0*AW +: AW] = 5'h01;
    req_addr[1*AW +: AW] = 5'h0b;
    #1;
    checks++;
    if (ack !== 4'b0001) begin failures++; $display("FAIL wd_ack0 got=%b exp=0001", ack); end
    tick();
    req = 4'b0000;
    #1;
    checks++;
    if (ack !== 4'b0000) begin failures++; $display("FAIL wd_idle_ack got=%b exp=0000", ack); end
    tick();
    checks++;
    if (rvalid !== 4'b0001) begin failures++; $display("FAIL wd_rvalid got=%b exp=0001", rvalid); end
    // Pointer sits at 1, so requester 1 beats requester 0 now.
    req = 4'b0011;
    #1;
    checks++;
    if (ack !== 4'b0010) begin failures++; $display("FAIL wd_ptr_ack got=%b exp=0010", ack); end
    tick();
    req = 4'b0000;
    checks++;
    if (rvalid !== 4'b0000) begin failures++; $display("FAIL wd_no_rvalid got=%b exp=0000", rvalid); end
    tick();
    checks++;
    if (rvalid !== 4'b0010) begin failures++; $display("FAIL wd_rvalid1 got=%b exp=0010", rvalid); end
    checks++;
    if (rdata !== 32'h459f_f800) begin failures++; $display("FAIL wd_rdata got=%h exp=459ff800", rdata); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_stream();
    test_fairness();
    test_reset_inflight();
    test_withdrawn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/foc_const_arb.md
Name: foc_const_arb

Overview:
- Round-robin arbiter that shares the single-port 32x32 FOC floating-point constant ROM among NUM_REQ datapath requesters.
- Requesters include the Clarke/Park stage, the PWM scaler and the angle unwrapper.
- Accepts one address per cycle, drives the ROM address register, and returns the ROM word with a one-hot valid tag to the winning requester.
- Sits between the FOC sequencing logic and the constant ROM; the ROM stays unchanged (registered output, 1-cycle read).

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- AW, 5, ROM address width
- DW, 32, ROM data width (IEEE-754 single)

Ports:
- c  in  1  clock
- r  in  1  reset (synchronous, active-high)
- req  in  NUM_REQ  per-requester read request, held until ack
- req_addr  in  NUM_REQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
- ack  out  NUM_REQ  one-hot combinational grant; request consumed at next rising edge of c
- rom_addr  out  AW  registered address to the constant ROM
- rom_q  in  DW  ROM registered output
- rdata  out  DW  returned constant, driven directly from rom_q
- rvalid  out  NUM_REQ  one-hot registered tag; rdata belongs to requester i when rvalid[i]=1

Behaviour:
- Reset (r=1 at an edge): rr_ptr=0, rom_addr=0, pipeline tags cleared, rvalid=0.
  - ack is forced to 0 while r=1.
  - In-flight reads are squashed with no rvalid; requesters must reissue.
- Arbitration is combinational from req and registered rr_ptr.
  - Winner is the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - ack = one-hot of winner; ack = 0 if req = 0.
  - Requesters must not form a combinational path from ack to req or req_addr.
- At edge E with a winner w:
  - rom_addr <= req_addr[w]
  - tag0 <= onehot(w)
  - rr_ptr <= (w+1) mod NUM_REQ
- With no winner at edge E: tag0 <= 0; rom_addr and rr_ptr hold.
- At edge E+1: the ROM latches rom_q from rom_addr; rvalid <= tag0.
  - rvalid[w]=1 for exactly the one cycle following E+1, with rdata = rom_q.
- Latency: ack cycle ending at edge E → rvalid in the cycle starting at E+1 (two edges).
- Throughput: one grant per cycle. A lone requester holding req may be granted every cycle with a new address each cycle.
- The pipeline never stalls; requesters must accept rvalid unconditionally (no ready).
- Fairness: with all req=1, grants rotate 0,1,2,3,0,... Any continuously asserted requester is granted within NUM_REQ cycles.
- Address 0x1F returns 0 and addresses 0x12..0x1E return 0 (ROM property). The arbiter does no range checking.
- req dropping without ack is legal (request withdrawn); no state changes.
- Simultaneous reset and request: reset wins, no ack.
- rom_addr holds its last value when idle, so the ROM re-reads harmlessly.

Decomposition:
- Shared package foc_pkg:
  - FOC_CONST_AW=5, FOC_DW=32
  - named ROM addresses: CONST_NEG_16384=5'h00, CONST_ADC_SCALE=5'h01, CONST_PWM_ZERO=5'h09, CONST_PWM_MAX=5'h0B, CONST_TWO_PI=5'h0F, CONST_ZERO=5'h1F
- One sub-module: rr_pick.
  - Parameterised round-robin picker.
  - Inputs: req, ptr. Outputs: onehot grant, encoded index, any.
  - Reused by the planned register-file port arbiter.

Test Plan:
- Reset then single request: req=4'b0001, addr0=5'h01 → ack[0] same cycle; two edges later rvalid=4'b0001, rdata=32'h3bd5_5555.
- All four request (addrs 5'h00, 5'h0B, 5'h0F, 5'h1F) held → acks rotate 0,1,2,3. rvalid/rdata return, one per cycle: c680_0000, 459f_f800, 40c9_0fdb, 0000_0000.
- Lone requester 2 streams addrs 5'h09, 5'h0a, 5'h0d on consecutive cycles → three consecutive rvalid=4'b0100 with rdata 451f_f000, 424c_b852, 3f00_0000.
- Fairness: req[0] held continuously while req[3] rises mid-stream → ack[3] within 4 cycles; rr_ptr wraps 3→0 correctly.
- Reset asserted one cycle after a grant for 5'h02 → no rvalid emitted, rom_addr=0, ack=0 during reset. After release, a new request for 5'h02 returns 3f2a_aaab.
- Withdrawn request: req[1] pulses while req[0] wins, then drops → no ack[1] and no rvalid[1]; rr_ptr advances only past requester 0.
